uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling, level-style
// valid / framing-error flags that hold until the next accepted start edge.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       framing_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [1:0]         sync_q;
  logic               rx_prev;
  logic               rx_s;
  logic               fall;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               half_done;
  logic               full_done;

  assign rx_s      = sync_q[1];
  assign fall      = rx_prev & ~rx_s;
  assign half_done = (cnt == CNT_W'(HALF_BIT - 1));
  assign full_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx_serial};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (fall) state_n = START;
      // a line that is high again at mid start bit was only a glitch
      START: if (half_done) state_n = rx_s ? IDLE : DATA;
      DATA:  if (full_done && bit_idx == 3'd7) state_n = STOP;
      STOP:  if (full_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            rx_data_valid <= 1'b0;
            framing_error <= 1'b0;
          end
        end
        START: begin
          if (half_done) begin
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (full_done) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (full_done) begin
            cnt           <= '0;
            rx_data       <= shreg;
            rx_data_valid <= rx_s;
            framing_error <= ~rx_s;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at a reduced ratio (16 clocks per bit) so whole frames stay short.
module tb_uart_rx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 62500;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int TCLK   = 10;
  localparam int TBIT   = CPB * TCLK;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       framing_error;

  int checks   = 0;
  int failures = 0;

  // reference model: what the receiver should currently present
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_ferr;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .framing_error(framing_error)
  );

  always #(TCLK/2) clk = ~clk;

  function automatic void model_reset();
    exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0;
  endfunction

  // a full frame: start edge clears flags, stop sample sets them
  function automatic void model_frame(input logic [7:0] b, input logic stop);
    exp_data = b; exp_valid = stop; exp_ferr = ~stop;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
    rx_serial = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      #(bit_t);
    end
    rx_serial = stop;
    #(bit_t);
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    #(n * TBIT);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_serial = 1'b1;
    #(3 * TCLK + 2);
    model_reset();
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL reset_state: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    @(negedge clk); rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_basic();
    send_frame(8'h55, 1'b1, TBIT);
    model_frame(8'h55, 1'b1);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL basic_55: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [2];
    seq[0] = 8'hA3; seq[1] = 8'hF0;
    for (int k = 0; k < 2; k++) begin
      fork
        send_frame(seq[k], 1'b1, TBIT);
        begin
          #(TBIT / 2);
          checks++;
          if (rx_data_valid !== 1'b0 || framing_error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drop_%0d: got v=%b fe=%b want v=0 fe=0", k, rx_data_valid, framing_error);
          end
        end
      join
      model_frame(seq[k], 1'b1);
      checks++;
      if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
        failures++;
        $display("FAIL b2b_byte_%0d: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
                 k, rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
      end
    end
    idle_bits(1);
  endtask

  task automatic test_framing_error();
    send_frame(8'h3C, 1'b0, TBIT);
    model_frame(8'h3C, 1'b0);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL ferr_3c: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    // line stays low (break): no new frame may start
    #(3 * TBIT);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL break_hold: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    idle_bits(2);
    send_frame(8'h81, 1'b1, TBIT);
    model_frame(8'h81, 1'b1);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL after_ferr_81: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    idle_bits(1);
  endtask

  task automatic test_glitch();
    rx_serial = 1'b0;
    #(3 * TCLK);
    rx_serial = 1'b1;
    // accepted edge clears flags; glitch leaves them cleared and data untouched
    exp_valid = 1'b0; exp_ferr = 1'b0;
    idle_bits(2);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL glitch: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    send_frame(8'h7E, 1'b1, TBIT);
    model_frame(8'h7E, 1'b1);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL after_glitch_7e: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    idle_bits(1);
  endtask

  task automatic test_reset_mid_frame();
    rx_serial = 1'b0;
    #(TBIT);
    for (int i = 0; i < 4; i++) begin
      rx_serial = 1'b1;
      #(TBIT);
    end
    #(TBIT / 2 + 3);
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL mid_reset: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    rx_serial = 1'b1;
    #(4 * TCLK);
    @(negedge clk); rst = 1'b0;
    idle_bits(2);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL post_reset_idle: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    send_frame(8'h12, 1'b1, TBIT);
    model_frame(8'h12, 1'b1);
    checks++;
    if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
      failures++;
      $display("FAIL after_reset_12: got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
               rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
    end
    idle_bits(1);
  endtask

  // random bytes, occasional bad stop bit, transmitter bit period off by up to ~2%
  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b;
      logic       stop;
      int         bit_t;
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      bit_t = TBIT - 3 + int'($urandom_range(0, 6));
      send_frame(b, stop, bit_t);
      model_frame(b, stop);
      checks++;
      if (rx_data !== exp_data || rx_data_valid !== exp_valid || framing_error !== exp_ferr) begin
        failures++;
        $display("FAIL random_%0d (bit_t=%0d): got data=%h v=%b fe=%b want data=%h v=%b fe=%b",
                 k, bit_t, rx_data, rx_data_valid, framing_error, exp_data, exp_valid, exp_ferr);
      end
      idle_bits(stop ? 0 : 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing_error();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
